// File: rtl/reg_debug_port_pkg.sv
// rtl/reg_debug_port_pkg.sv - shared constants and FSM state encoding for the register debug port
package reg_debug_port_pkg;

  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DUMP   = 2'd1;
  localparam state_t ST_LOAD   = 2'd2;
  localparam state_t ST_FINISH = 2'd3;

endpackage

// File: rtl/reg_debug_range_ctr.sv
// rtl/reg_debug_range_ctr.sv - register range walker: pointer with wrap and remaining-word count
module reg_debug_range_ctr #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] first,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W-1:0] ptr_next,
  output logic [ADDR_W:0]   remaining,
  output logic              zero,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W + 1)'(NUM_REGS);

  assign ptr_next = (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
  assign zero     = (remaining == '0);
  assign last     = (remaining == (ADDR_W + 1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      remaining <= '0;
    end else if (load) begin
      ptr       <= first;
      remaining <= (count > MAX_COUNT) ? MAX_COUNT : count;
    end else if (step) begin
      ptr       <= ptr_next;
      remaining <= remaining - (ADDR_W + 1)'(1);
    end
  end

endmodule

// File: rtl/reg_debug_port.sv
// rtl/reg_debug_port.sv - debug engine that dumps/loads a register range and halts the core while busy
module reg_debug_port
  import reg_debug_port_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START_DUMP,
  input  logic              START_LOAD,
  input  logic [ADDR_W-1:0] FIRST,
  input  logic [ADDR_W:0]   COUNT,
  output logic              BUSY,
  output logic              HALT,
  output logic              DONE,
  output logic [ADDR_W-1:0] A_RD,
  input  logic [DATA_W-1:0] RD,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              WE3,
  output logic              DOUT_VALID,
  input  logic              DOUT_READY,
  output logic [DATA_W-1:0] DOUT_DATA,
  output logic [ADDR_W-1:0] DOUT_ADDR,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  input  logic [DATA_W-1:0] DIN_DATA
);

  state_t            state;
  logic              primed;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_next;
  logic [ADDR_W:0]   remaining;
  logic              zero;
  logic              last;

  logic idle, count_nz, start_dump, start_load;
  logic capture, din_fire, last_out;

  assign idle       = (state == ST_IDLE);
  assign count_nz   = (COUNT != '0);
  assign start_dump = idle && START_DUMP && count_nz;
  assign start_load = idle && START_LOAD && !START_DUMP && count_nz;

  // The first DUMP cycle only lets the registered A_RD settle before RD is captured.
  assign capture   = (state == ST_DUMP) && primed && !zero && (!DOUT_VALID || DOUT_READY);
  assign last_out  = (state == ST_DUMP) && DOUT_VALID && DOUT_READY && zero;
  assign DIN_READY = (state == ST_LOAD) && !zero;
  assign din_fire  = DIN_READY && DIN_VALID;
  assign HALT      = BUSY;

  reg_debug_range_ctr #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_range (
    .clk       (CLK),
    .rst       (RST),
    .load      (start_dump || start_load),
    .step      (capture || din_fire),
    .first     (FIRST),
    .count     (COUNT),
    .ptr       (ptr),
    .ptr_next  (ptr_next),
    .remaining (remaining),
    .zero      (zero),
    .last      (last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      primed     <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      A_RD       <= '0;
      A3         <= '0;
      WD3        <= '0;
      WE3        <= 1'b0;
      DOUT_VALID <= 1'b0;
      DOUT_DATA  <= '0;
      DOUT_ADDR  <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_dump) begin
            state  <= ST_DUMP;
            BUSY   <= 1'b1;
            primed <= 1'b0;
            A_RD   <= FIRST;
          end else if (start_load) begin
            state <= ST_LOAD;
            BUSY  <= 1'b1;
          end
        end
        ST_DUMP: begin
          primed <= 1'b1;
          if (capture) begin
            DOUT_DATA  <= RD;
            DOUT_ADDR  <= ptr;
            DOUT_VALID <= 1'b1;
            A_RD       <= ptr_next;
          end else if (DOUT_READY && zero) begin
            DOUT_VALID <= 1'b0;
          end
          if (last_out) begin
            state <= ST_FINISH;
            DONE  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (din_fire) begin
            A3  <= ptr;
            WD3 <= DIN_DATA;
            WE3 <= 1'b1;
            if (last) begin
              state <= ST_FINISH;
              DONE  <= 1'b1;
            end
          end else begin
            WE3 <= 1'b0;
          end
        end
        ST_FINISH: begin
          WE3        <= 1'b0;
          DOUT_VALID <= 1'b0;
          BUSY       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/reg_debug_port.md
Name: reg_debug_port

Overview:
- Debug-side access engine for the 32x32 register file.
- DUMP: reads a contiguous register range through one asynchronous read port and streams it out over a valid/ready interface.
- LOAD: accepts a valid/ready word stream and writes it into a range through the synchronous write port.
- Asserts HALT while busy. Top level uses HALT to mux the regfile ports away from the datapath.

Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- NUM_REGS, 32, register count; addresses wrap modulo NUM_REGS

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- START_DUMP  input  1  single-cycle request to start a dump
- START_LOAD  input  1  single-cycle request to start a load
- FIRST  input  ADDR_W  first register address; sampled at start
- COUNT  input  ADDR_W+1  number of registers; sampled at start
- BUSY  output  1  high from accepted start until DONE
- HALT  output  1  equal to BUSY; freezes the core
- DONE  output  1  one-cycle pulse at end of operation
- A_RD  output  ADDR_W  read address to regfile
- RD  input  DATA_W  asynchronous read data from regfile
- A3  output  ADDR_W  write address to regfile
- WD3  output  DATA_W  write data to regfile
- WE3  output  1  write enable to regfile
- DOUT_VALID  output  1  dump word valid
- DOUT_READY  input  1  dump consumer ready
- DOUT_DATA  output  DATA_W  dumped register value
- DOUT_ADDR  output  ADDR_W  address of DOUT_DATA
- DIN_VALID  input  1  load word valid
- DIN_READY  output  1  load word accepted when high with DIN_VALID
- DIN_DATA  input  DATA_W  load word

Behaviour:
- Reset: state IDLE. All outputs 0: BUSY, HALT, DONE, A_RD, A3, WD3, WE3, DOUT_*, DIN_READY. ptr=0, remaining=0.
- Reset mid-operation: abort immediately. No DONE. Any pending WE3 is dropped.
- States: IDLE, DUMP, LOAD, FINISH.
- IDLE to DUMP: START_DUMP=1 and COUNT!=0. Latch ptr=FIRST and remaining=min(COUNT,NUM_REGS).
- IDLE to LOAD: START_LOAD=1 and COUNT!=0, with the same latching.
- Both starts high in the same cycle: DUMP wins.
- COUNT=0: start is ignored; the block stays IDLE with no DONE.
- Starts while BUSY are ignored.
- BUSY and HALT are registered, high from the edge that accepts the start.
- DUMP, address: A_RD=ptr (registered copy).
- DUMP, capture: a capture occurs when remaining!=0 and (!DOUT_VALID or DOUT_READY). On capture: DOUT_DATA<=RD, DOUT_ADDR<=ptr, DOUT_VALID<=1, ptr<=ptr+1 mod NUM_REGS, remaining--.
- DUMP, drain: if DOUT_READY and remaining==0, DOUT_VALID<=0.
- DUMP, data stability: DOUT_DATA and DOUT_ADDR stay stable while DOUT_VALID && !DOUT_READY.
- DUMP, latency and throughput: first DOUT_VALID is 2 edges after the start edge. Sustains 1 word/cycle with DOUT_READY held high.
- DUMP, exit: the handshake of the last word moves the block to FINISH.
- LOAD, ready: DIN_READY=1 while remaining!=0.
- LOAD, accept: on DIN_VALID&&DIN_READY, register A3<=ptr, WD3<=DIN_DATA, WE3<=1, then ptr++ (wrap) and remaining--.
- LOAD, no accept: WE3<=0.
- LOAD, commit: the regfile commits each word on the edge after WE3 rises.
- LOAD, exit: the last accept moves the block to FINISH. WE3 for the last word is high during the first FINISH cycle.
- FINISH: DONE=1 for exactly one cycle. WE3<=0, DOUT_VALID=0, then IDLE. BUSY and HALT fall with the IDLE transition.
- Wrap-around: FIRST=30 with COUNT=4 accesses 30, 31, 0, 1.
- Register 0 has no special treatment; it is readable and writable.
- DIN_DATA is ignored outside LOAD. DOUT_READY is ignored outside DUMP.

Decomposition:
- Shared package: state enum (IDLE/DUMP/LOAD/FINISH), NUM_REGS, ADDR_W, DATA_W.
- Natural sub-module: reg_debug_range_ctr, covering ptr and remaining load, wrap-increment and zero-detect. It is used by both modes.
- FSM and stream logic stay in the top module.

Test Plan:
- Dump, full rate: regs[i]=i*3. START_DUMP, FIRST=2, COUNT=3, READY=1 → DOUT words (2,6),(3,9),(4,12) on consecutive cycles. DONE one cycle after the last handshake. HALT high throughout.
- Dump, backpressure: READY toggles 1,0,0,1 → no word lost or duplicated. DOUT_DATA held stable while stalled.
- Load: START_LOAD, FIRST=31, COUNT=2, DIN words 0xDEADBEEF, 0x12345678 → WE3 pulses at A3=31 then A3=0. Regfile holds the values afterwards.
- Load, gaps: DIN_VALID drops for 2 cycles mid-stream → WE3 low during the gap. Exactly COUNT writes occur.
- Edge starts: COUNT=0 → no BUSY. Both starts high → dump performed. COUNT=40 → 32 words.
- Reset: RST during LOAD after 1 of 4 words → WE3=0 and BUSY=0 next cycle. No DONE. Only word 1 written.
